// File: rtl/startpulse_gen_if.sv
// -----------------------------------------------------------------------------
// startpulse_gen_if
//   Bundles the start/acknowledge handshake and the status outputs of
//   startpulse_gen so producer and consumer share one port.
//
//   Signals
//     start_o      producer -> consumer  registered start pulse
//     ack_i        consumer -> producer  acknowledge of a start pulse
//     busy_o       producer -> consumer  sequence in progress
//     done_o       producer -> consumer  sticky, all pulses acknowledged
//     timeout_o    producer -> consumer  sticky, acknowledge never arrived
//     spurious_o   producer -> consumer  sticky, acknowledge outside a pulse
//     pulse_cnt_o  producer -> consumer  number of acknowledged pulses
//
//   Modports
//     master  the pulse generator (startpulse_gen)
//     slave   the consumer of the start pulses
// -----------------------------------------------------------------------------
interface startpulse_gen_if #(
  parameter int NUM_PULSES = 2
);
  localparam int CNT_W = (NUM_PULSES < 1) ? 1 : $clog2(NUM_PULSES + 1);

  logic             start_o;
  logic             ack_i;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic             spurious_o;
  logic [CNT_W-1:0] pulse_cnt_o;

  modport master (
    output start_o,
    output busy_o,
    output done_o,
    output timeout_o,
    output spurious_o,
    output pulse_cnt_o,
    input  ack_i
  );

  modport slave (
    input  start_o,
    input  busy_o,
    input  done_o,
    input  timeout_o,
    input  spurious_o,
    input  pulse_cnt_o,
    output ack_i
  );
endinterface

// File: rtl/startpulse_gen.sv
// -----------------------------------------------------------------------------
// startpulse_gen
//   Issues NUM_PULSES start pulses to a consumer. The first pulse appears
//   DELAY cycles after reset release, each pulse lasts PULSE_W cycles (or
//   less if acknowledged early), and after each accepted acknowledge the
//   block idles GAP cycles before the next pulse. An acknowledge that does
//   not arrive within TIMEOUT cycles after the pulse ends is a failure.
//   DONE and FAIL are terminal until reset.
//
//   Ports
//     clk      single clock, rising edge
//     reset_l  synchronous, active-low reset
//     bus      startpulse_gen_if.master (start_o, ack_i, busy_o, done_o,
//              timeout_o, spurious_o, pulse_cnt_o); all outputs registered
//
//   The interface instance must be built with the same NUM_PULSES.
// -----------------------------------------------------------------------------
module startpulse_gen #(
  parameter int DELAY      = 4,
  parameter int PULSE_W    = 1,
  parameter int GAP        = 3,
  parameter int NUM_PULSES = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                clk,
  input  logic                reset_l,
  startpulse_gen_if.master    bus
);

  // ---------------------------------------------------------------------------
  // Parameter checks
  // ---------------------------------------------------------------------------
  if (PULSE_W < 1) begin : g_bad_pulse_w
    $error("startpulse_gen: PULSE_W must be >= 1 (got %0d)", PULSE_W);
  end
  if (NUM_PULSES < 1) begin : g_bad_num_pulses
    $error("startpulse_gen: NUM_PULSES must be >= 1 (got %0d)", NUM_PULSES);
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("startpulse_gen: TIMEOUT must be >= 1 (got %0d)", TIMEOUT);
  end

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int MAX_DG = (DELAY > GAP) ? DELAY : GAP;
  localparam int MAX_PT = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
  localparam int MAX_V  = (MAX_DG > MAX_PT) ? MAX_DG : MAX_PT;
  localparam int CW     = (MAX_V < 1) ? 1 : $clog2(MAX_V + 1);
  localparam int CNT_W  = (NUM_PULSES < 1) ? 1 : $clog2(NUM_PULSES + 1);

  localparam logic [CW-1:0]    DELAY_C = CW'(DELAY);
  localparam logic [CW-1:0]    GAP_C   = CW'(GAP);
  // PULSE and WAIT_ACK count from 0, so the last counted cycle is N-1.
  localparam logic [CW-1:0]    PW_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0]    TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NP_LAST = CNT_W'(NUM_PULSES - 1);

  typedef enum logic [2:0] {
    WAIT_DLY,
    PULSE,
    WAIT_ACK,
    DONE,
    FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;        // cycles spent in the current state
  logic          first;      // still waiting for the very first pulse
  logic [CW-1:0] dly_target;

  // The first idle period uses DELAY, every later one uses GAP.
  assign dly_target = first ? DELAY_C : GAP_C;

  // ---------------------------------------------------------------------------
  // Sequencer: state, counters and every output in one registered block
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled synchronously here, so reset_l sits inside the
  // clocked branch and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state           <= WAIT_DLY;
      cnt             <= '0;
      first           <= 1'b1;
      bus.start_o     <= 1'b0;
      bus.busy_o      <= 1'b1;
      bus.done_o      <= 1'b0;
      bus.timeout_o   <= 1'b0;
      bus.spurious_o  <= 1'b0;
      bus.pulse_cnt_o <= '0;
    end else begin
      // NOTE: every assignment here is non-blocking so each register sees the
      // pre-edge value of the others, regardless of statement order.
      case (state)
        WAIT_DLY: begin
          // An acknowledge here is flagged but does not disturb the countdown.
          if (bus.ack_i) bus.spurious_o <= 1'b1;
          if (cnt >= dly_target) begin
            state       <= PULSE;
            cnt         <= '0;
            first       <= 1'b0;
            bus.start_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PULSE, WAIT_ACK: begin
          if (bus.ack_i) begin
            // Acceptance ends the pulse early if it is still high.
            bus.start_o     <= 1'b0;
            cnt             <= '0;
            bus.pulse_cnt_o <= bus.pulse_cnt_o + 1'b1;
            if (bus.pulse_cnt_o == NP_LAST) begin
              state       <= DONE;
              bus.done_o  <= 1'b1;
              bus.busy_o  <= 1'b0;
            end else begin
              state <= WAIT_DLY;
            end
          end else if (state == PULSE) begin
            if (cnt == PW_LAST) begin
              state       <= WAIT_ACK;
              cnt         <= '0;
              bus.start_o <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            // Acknowledge on the last counted cycle was handled above, so it
            // takes priority over the timeout.
            if (cnt == TO_LAST) begin
              state         <= FAIL;
              bus.timeout_o <= 1'b1;
              bus.busy_o    <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE, FAIL: begin
          if (bus.ack_i) bus.spurious_o <= 1'b1;
        end

        default: begin
          // Unreachable encodings park in FAIL with outputs quiet.
          state       <= FAIL;
          bus.start_o <= 1'b0;
          bus.busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_startpulse_gen.sv
// -----------------------------------------------------------------------------
// tb_startpulse_gen
//   Two generators share clock and reset: u_dut0 with default parameters and
//   u_dut1 with DELAY=0, PULSE_W=3. Each scenario queues expected output
//   snapshots tagged with the edge index (E0 = first edge sampling reset_l=1,
//   -1 while in reset); a monitor on the falling edge pops and compares every
//   entry whose edge index has been reached.
// -----------------------------------------------------------------------------
module tb_startpulse_gen;

  logic clk     = 1'b0;
  logic reset_l = 1'b0;

  always #5 clk = ~clk;

  startpulse_gen_if #(.NUM_PULSES(2)) if0 ();
  startpulse_gen_if #(.NUM_PULSES(2)) if1 ();

  startpulse_gen u_dut0 (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (if0.master)
  );

  startpulse_gen #(
    .DELAY   (0),
    .PULSE_W (3)
  ) u_dut1 (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (if1.master)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          dut;
    int          cyc;
    string       name;
    logic [6:0]  vec;   // {start, busy, done, timeout, spurious, pulse_cnt[1:0]}
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   e_idx = -1;

  // Edge index: -1 while reset is sampled low, then 0, 1, 2 ...
  always @(posedge clk) begin
    if (!reset_l) e_idx <= -1;
    else          e_idx <= e_idx + 1;
  end

  function automatic logic [6:0] snap(input int dut);
    if (dut == 0)
      return {if0.start_o, if0.busy_o, if0.done_o, if0.timeout_o,
              if0.spurious_o, if0.pulse_cnt_o};
    else
      return {if1.start_o, if1.busy_o, if1.done_o, if1.timeout_o,
              if1.spurious_o, if1.pulse_cnt_o};
  endfunction

  task automatic push(input int dut, input int cyc, input string name,
                      input logic st, input logic bs, input logic dn,
                      input logic tm, input logic sp, input logic [1:0] cn);
    exp_t e;
    e.dut  = dut;
    e.cyc  = cyc;
    e.name = name;
    e.vec  = {st, bs, dn, tm, sp, cn};
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [6:0] act;
    while (q.size() > 0 && q[0].cyc == e_idx) begin
      act   = snap(q[0].dut);
      total = total + 1;
      if (act !== q[0].vec) begin
        bad = bad + 1;
        $display("FAIL %s dut%0d E%0d: got {st,bsy,dn,to,sp,cnt}=%b required %b",
                 q[0].name, q[0].dut, e_idx, act, q[0].vec);
      end
      void'(q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    @(posedge clk); #1;
    reset_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_l = 1'b1;
  endtask

  task automatic at_e(input int n);
    int guard = 0;
    while (e_idx != n && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (e_idx != n) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL wait_edge: edge index %0d required %0d", e_idx, n);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() > 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: pending=%0d required 0 (next %s at E%0d)",
               q.size(), q[0].name, q[0].cyc);
      q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    if0.ack_i = 1'b0;
    if1.ack_i = 1'b0;

    // Reset values, then two acknowledged pulses (ack one cycle after rise).
    push(0, -1, "rst_dut0",  0, 1, 0, 0, 0, 2'd0);
    push(1, -1, "rst_dut1",  0, 1, 0, 0, 0, 2'd0);
    push(0,  3, "a_idle_e3", 0, 1, 0, 0, 0, 2'd0);
    push(0,  4, "a_pulse1",  1, 1, 0, 0, 0, 2'd0);
    push(0,  5, "a_ack1",    0, 1, 0, 0, 0, 2'd1);
    push(0,  8, "a_gap_e8",  0, 1, 0, 0, 0, 2'd1);
    push(0,  9, "a_pulse2",  1, 1, 0, 0, 0, 2'd1);
    push(0, 10, "a_done",    0, 0, 1, 0, 0, 2'd2);
    push(0, 12, "a_term",    0, 0, 1, 0, 0, 2'd2);
    apply_reset();
    at_e(4);  if0.ack_i = 1'b1;
    at_e(5);  if0.ack_i = 1'b0;
    at_e(9);  if0.ack_i = 1'b1;
    at_e(10); if0.ack_i = 1'b0;
    drain();

    // No acknowledge: timeout on both generators; dut1 pulse is 3 wide.
    push(1,  0, "w_pulse_e0", 1, 1, 0, 0, 0, 2'd0);
    push(1,  2, "w_pulse_e2", 1, 1, 0, 0, 0, 2'd0);
    push(1,  3, "w_drop_e3",  0, 1, 0, 0, 0, 2'd0);
    push(0,  4, "b_pulse",    1, 1, 0, 0, 0, 2'd0);
    push(1, 10, "w_pre_tmo",  0, 1, 0, 0, 0, 2'd0);
    push(1, 11, "w_tmo",      0, 0, 0, 1, 0, 2'd0);
    push(0, 12, "b_pre_tmo",  0, 1, 0, 0, 0, 2'd0);
    push(0, 13, "b_tmo",      0, 0, 0, 1, 0, 2'd0);
    push(0, 15, "b_term",     0, 0, 0, 1, 0, 2'd0);
    apply_reset();
    drain();

    // Acknowledge sampled at E2 while idling: spurious, sequence unchanged.
    push(0, 1, "c_e1",    0, 1, 0, 0, 0, 2'd0);
    push(0, 2, "c_spur",  0, 1, 0, 0, 1, 2'd0);
    push(0, 3, "c_e3",    0, 1, 0, 0, 1, 2'd0);
    push(0, 4, "c_pulse", 1, 1, 0, 0, 1, 2'd0);
    apply_reset();
    at_e(1); if0.ack_i = 1'b1;
    at_e(2); if0.ack_i = 1'b0;
    drain();

    // Reset sampled at E5 in the middle of the pulse, then a fresh sequence.
    push(0,  3, "d_spur",     0, 1, 0, 0, 1, 2'd0);
    push(0,  4, "d_pulse",    1, 1, 0, 0, 1, 2'd0);
    push(0, -1, "d_abort",    0, 1, 0, 0, 0, 2'd0);
    push(0,  3, "d_re_e3",    0, 1, 0, 0, 0, 2'd0);
    push(0,  4, "d_re_pulse", 1, 1, 0, 0, 0, 2'd0);
    apply_reset();
    at_e(1); if0.ack_i = 1'b1;
    at_e(2); if0.ack_i = 1'b0;
    at_e(4); reset_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_l = 1'b1;
    drain();

    // Acknowledge on the 8th WAIT_ACK cycle (E13) wins over the timeout.
    push(0, 12, "e_e12",    0, 1, 0, 0, 0, 2'd0);
    push(0, 13, "e_ack8",   0, 1, 0, 0, 0, 2'd1);
    push(0, 16, "e_gap",    0, 1, 0, 0, 0, 2'd1);
    push(0, 17, "e_pulse2", 1, 1, 0, 0, 0, 2'd1);
    apply_reset();
    at_e(12); if0.ack_i = 1'b1;
    at_e(13); if0.ack_i = 1'b0;
    drain();

    // DELAY=0, PULSE_W=3: ack high from E0 cuts the pulse at E1, no spurious.
    push(1, 0, "f_pulse",   1, 1, 0, 0, 0, 2'd0);
    push(1, 1, "f_ack",     0, 1, 0, 0, 0, 2'd1);
    push(1, 2, "f_nospur",  0, 1, 0, 0, 0, 2'd1);
    apply_reset();
    at_e(0); if1.ack_i = 1'b1;
    at_e(1); if1.ack_i = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
